// File: rtl/midi_pkg.sv
// ============================================================================
// Package : midi_pkg
// Purpose : Shared MIDI definitions for the MIDI input path: status byte
//           constants, the receiver FSM state type, the queued message record
//           and a helper returning how many data bytes a status byte needs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package midi_pkg;

  // Channel voice status bytes (high nibble; low nibble is the channel)
  localparam logic [7:0] NOTE_OFF         = 8'h80;
  localparam logic [7:0] NOTE_ON          = 8'h90;
  localparam logic [7:0] POLY_PRESSURE    = 8'hA0;
  localparam logic [7:0] CONTROL_CHANGE   = 8'hB0;
  localparam logic [7:0] PROGRAM_CHANGE   = 8'hC0;
  localparam logic [7:0] CHANNEL_PRESSURE = 8'hD0;
  localparam logic [7:0] PITCH_BEND       = 8'hE0;

  // System common / exclusive
  localparam logic [7:0] SYSEX_START      = 8'hF0;
  localparam logic [7:0] TIME_CODE        = 8'hF1;
  localparam logic [7:0] SONG_POSITION    = 8'hF2;
  localparam logic [7:0] SONG_SELECT      = 8'hF3;
  localparam logic [7:0] TUNE_REQUEST     = 8'hF6;
  localparam logic [7:0] SYSEX_END        = 8'hF7;

  // Anything at or above this is a single-byte real-time message
  localparam logic [7:0] RT_MIN           = 8'hF8;

  // Message record: {len, status, data1, data2}
  localparam int MSG_W = 26;

  typedef struct packed {
    logic [1:0] len;
    logic [7:0] status;
    logic [7:0] d1;
    logic [7:0] d2;
  } midi_msg_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // Data bytes that follow a status byte. Zero means the status either
  // stands alone or opens no message (SysEx, undefined, tune request).
  function automatic logic [1:0] data_bytes_needed(input logic [7:0] status);
    logic [1:0] n;
    n = 2'd0;
    if (status[7] && (status < SYSEX_START)) begin
      n = ((status[7:4] == 4'hC) || (status[7:4] == 4'hD)) ? 2'd1 : 2'd2;
    end else if ((status == TIME_CODE) || (status == SONG_SELECT)) begin
      n = 2'd1;
    end else if (status == SONG_POSITION) begin
      n = 2'd2;
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/midi_uart_rx.sv
// ============================================================================
// Module  : midi_uart_rx
// Purpose : Oversampled 8N1 serial receiver for the MIDI opto input.
//           Synchronises the raw line, detects the start edge, samples each
//           bit in its centre and reports the byte or a framing error.
// Ports   : i_clock        system clock
//           i_clr          asynchronous active-low reset
//           i_midi_data    raw serial line (idles high)
//           o_byte         last received byte, stable during o_byte_valid
//           o_byte_valid   one-cycle pulse: byte received with good stop bit
//           o_framing_err  one-cycle pulse: stop bit sampled low
//           o_busy_reading receiver is inside a frame
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module midi_uart_rx #(
  parameter int CLKS_PER_BIT = 1600,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       i_clock,
  input  logic       i_clr,
  input  logic       i_midi_data,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_framing_err,
  output logic       o_busy_reading
);
  import midi_pkg::*;

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] C_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(CLKS_PER_BIT - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_prev;
  rx_state_e              r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [2:0]             r_bit;
  logic [7:0]             r_shift;
  logic                   r_byte_valid;
  logic                   r_framing_err;

  logic                   w_s;
  rx_state_e              w_state_nxt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [2:0]             w_bit_nxt;
  logic [7:0]             w_shift_nxt;
  logic                   w_byte_valid_nxt;
  logic                   w_framing_err_nxt;

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clock or negedge i_clr) begin
    if (!i_clr) begin
      r_sync        <= '1;
      r_s_prev      <= 1'b1;
      r_state       <= RX_IDLE;
      r_cnt         <= '0;
      r_bit         <= '0;
      r_shift       <= '0;
      r_byte_valid  <= 1'b0;
      r_framing_err <= 1'b0;
    end else begin
      r_sync        <= {r_sync[SYNC_STAGES-2:0], i_midi_data};
      r_s_prev      <= w_s;
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_bit         <= w_bit_nxt;
      r_shift       <= w_shift_nxt;
      r_byte_valid  <= w_byte_valid_nxt;
      r_framing_err <= w_framing_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_bit_nxt         = r_bit;
    w_shift_nxt       = r_shift;
    w_byte_valid_nxt  = 1'b0;
    w_framing_err_nxt = 1'b0;
    case (r_state)
      RX_IDLE: begin
        // Falling edge on the synchronised line: aim for the start bit centre
        if (r_s_prev && !w_s) begin
          w_state_nxt = RX_START;
          w_cnt_nxt   = C_HALF;
        end
      end
      RX_START: begin
        if (r_cnt == '0) begin
          if (!w_s) begin
            w_state_nxt = RX_DATA;
            w_bit_nxt   = 3'd0;
            w_cnt_nxt   = C_FULL;
          end else begin
            // Line already back high at mid start bit: treat as a glitch
            w_state_nxt = RX_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      RX_DATA: begin
        if (r_cnt == '0) begin
          w_shift_nxt = {w_s, r_shift[7:1]};
          w_cnt_nxt   = C_FULL;
          w_bit_nxt   = r_bit + 3'd1;
          if (r_bit == 3'd7) begin
            w_state_nxt = RX_STOP;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      RX_STOP: begin
        if (r_cnt == '0) begin
          w_byte_valid_nxt  = w_s;
          w_framing_err_nxt = !w_s;
          w_state_nxt       = RX_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = RX_IDLE;
    endcase
  end

  assign o_byte         = r_shift;
  assign o_byte_valid   = r_byte_valid;
  assign o_framing_err  = r_framing_err;
  assign o_busy_reading = (r_state != RX_IDLE);

endmodule

`default_nettype wire

// File: rtl/midi_rx_parser.sv
// ============================================================================
// Module  : midi_rx_parser
// Purpose : MIDI input front end: serial receiver, message parser with
//           running status, real-time interleave, SysEx skip and channel
//           filter, followed by an output message FIFO.
// Ports   : i_clock        system clock
//           i_clr          asynchronous active-low reset
//           i_midi_data    raw serial MIDI line (idles high)
//           i_msg_ready    consumer accepts o_msg_data this cycle
//           o_msg_valid    FIFO non-empty; o_msg_data/o_msg_len valid
//           o_msg_data     {status, data1, data2}, unused bytes zero
//           o_msg_len      bytes in message (1..3)
//           o_busy_reading receiver inside a frame
//           o_framing_err  one-cycle pulse on a low stop bit
//           o_overflow     sticky: a message was dropped on a full FIFO
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module midi_rx_parser
  import midi_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 1600,
  parameter int          SYNC_STAGES  = 2,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [15:0] CHANNEL_MASK = 16'hFFFF
) (
  input  logic        i_clock,
  input  logic        i_clr,
  input  logic        i_midi_data,
  input  logic        i_msg_ready,
  output logic        o_msg_valid,
  output logic [23:0] o_msg_data,
  output logic [1:0]  o_msg_len,
  output logic        o_busy_reading,
  output logic        o_framing_err,
  output logic        o_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] C_FULL_LEVEL = (PTR_W + 1)'(FIFO_DEPTH);

  // ---------------------------------------------------------------- receiver
  logic [7:0] w_byte;
  logic       w_byte_valid;
  logic       w_framing_err;

  midi_uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .SYNC_STAGES  (SYNC_STAGES)
  ) u_uart_rx (
    .i_clock        (i_clock),
    .i_clr          (i_clr),
    .i_midi_data    (i_midi_data),
    .o_byte         (w_byte),
    .o_byte_valid   (w_byte_valid),
    .o_framing_err  (w_framing_err),
    .o_busy_reading (o_busy_reading)
  );

  assign o_framing_err = w_framing_err;

  // ------------------------------------------------------------------ parser
  logic [7:0] r_status;
  logic       r_have_status;   // a status is armed and accepts data
  logic [1:0] r_need;
  logic       r_have_d1;       // first of two data bytes captured
  logic [7:0] r_d1;
  logic       r_sysex;
  logic       r_push;
  midi_msg_t  r_push_msg;

  logic [7:0] w_status_nxt;
  logic       w_have_status_nxt;
  logic [1:0] w_need_nxt;
  logic       w_have_d1_nxt;
  logic [7:0] w_d1_nxt;
  logic       w_sysex_nxt;
  logic       w_push_nxt;
  midi_msg_t  w_push_msg_nxt;
  logic       w_chan_pass;

  // System common messages carry no channel and are never filtered
  assign w_chan_pass = (r_status >= SYSEX_START) || CHANNEL_MASK[r_status[3:0]];

  always_comb begin
    w_status_nxt      = r_status;
    w_have_status_nxt = r_have_status;
    w_need_nxt        = r_need;
    w_have_d1_nxt     = r_have_d1;
    w_d1_nxt          = r_d1;
    w_sysex_nxt       = r_sysex;
    w_push_nxt        = 1'b0;
    w_push_msg_nxt    = '0;
    if (w_framing_err) begin
      w_have_status_nxt = 1'b0;
      w_have_d1_nxt     = 1'b0;
      w_sysex_nxt       = 1'b0;
    end else if (w_byte_valid) begin
      if (w_byte >= RT_MIN) begin
        // Real-time bytes pass straight through without disturbing state
        w_push_nxt     = 1'b1;
        w_push_msg_nxt = '{len: 2'd1, status: w_byte, d1: 8'h00, d2: 8'h00};
      end else if (w_byte[7]) begin
        // Any non-real-time status restarts assembly; only statuses that
        // expect data stay armed, which clears running status for the rest.
        w_status_nxt      = w_byte;
        w_need_nxt        = data_bytes_needed(w_byte);
        w_have_status_nxt = (data_bytes_needed(w_byte) != 2'd0);
        w_have_d1_nxt     = 1'b0;
        w_sysex_nxt       = (w_byte == SYSEX_START);
        if (w_byte == TUNE_REQUEST) begin
          w_push_nxt     = 1'b1;
          w_push_msg_nxt = '{len: 2'd1, status: w_byte, d1: 8'h00, d2: 8'h00};
        end
      end else if (r_have_status && !r_sysex) begin
        if ((r_need == 2'd1) || r_have_d1) begin
          w_push_nxt         = w_chan_pass;
          w_push_msg_nxt.len = r_need + 2'd1;
          w_push_msg_nxt.status = r_status;
          w_push_msg_nxt.d1  = (r_need == 2'd1) ? w_byte : r_d1;
          w_push_msg_nxt.d2  = (r_need == 2'd1) ? 8'h00 : w_byte;
          w_have_d1_nxt      = 1'b0;
          // Running status survives only for channel voice messages
          if (r_status >= SYSEX_START) begin
            w_have_status_nxt = 1'b0;
          end
        end else begin
          w_d1_nxt      = w_byte;
          w_have_d1_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_clr) begin
    if (!i_clr) begin
      r_status      <= '0;
      r_have_status <= 1'b0;
      r_need        <= '0;
      r_have_d1     <= 1'b0;
      r_d1          <= '0;
      r_sysex       <= 1'b0;
      r_push        <= 1'b0;
      r_push_msg    <= '0;
    end else begin
      r_status      <= w_status_nxt;
      r_have_status <= w_have_status_nxt;
      r_need        <= w_need_nxt;
      r_have_d1     <= w_have_d1_nxt;
      r_d1          <= w_d1_nxt;
      r_sysex       <= w_sysex_nxt;
      r_push        <= w_push_nxt;
      r_push_msg    <= w_push_msg_nxt;
    end
  end

  // -------------------------------------------------------------------- FIFO
  midi_msg_t        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_level;
  logic             r_overflow;

  logic             w_full;
  logic             w_pop;
  logic             w_wr;
  midi_msg_t        w_head;

  assign w_full = (r_level == C_FULL_LEVEL);
  assign w_pop  = o_msg_valid && i_msg_ready;
  // A pop in the same cycle frees a slot, so a push onto a full FIFO is kept
  assign w_wr   = r_push && (!w_full || w_pop);

  always_ff @(posedge i_clock) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= r_push_msg;
    end
  end

  always_ff @(posedge i_clock or negedge i_clr) begin
    if (!i_clr) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_wr && !w_pop) begin
        r_level <= r_level + 1'b1;
      end else if (!w_wr && w_pop) begin
        r_level <= r_level - 1'b1;
      end
      if (r_push && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign w_head      = r_mem[r_rd_ptr];
  assign o_msg_valid = (r_level != '0);
  assign o_msg_data  = o_msg_valid ? {w_head.status, w_head.d1, w_head.d2} : 24'h0;
  assign o_msg_len   = o_msg_valid ? w_head.len : 2'd0;
  assign o_overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_midi_rx_parser.sv
// ============================================================================
// Module  : tb_midi_rx_parser
// Purpose : Self-checking bench for midi_rx_parser. A byte-level message
//           model predicts the message stream; a compare process checks each
//           accepted message and output stability while held.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_midi_rx_parser;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam logic [15:0] MASK1 = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        line1 = 1'b1;
  logic        line2 = 1'b1;
  logic        msg_ready = 1'b1;
  logic        ready2 = 1'b1;

  logic        valid1, busy1, ferr1, ovf1;
  logic [23:0] data1;
  logic [1:0]  len1;
  logic        valid2, busy2, ferr2, ovf2;
  logic [23:0] data2;
  logic [1:0]  len2;

  always #5 clk = ~clk;

  midi_rx_parser #(
    .CLKS_PER_BIT (CPB), .SYNC_STAGES (2), .FIFO_DEPTH (DEPTH), .CHANNEL_MASK (MASK1)
  ) dut (
    .i_clock (clk), .i_clr (rst_n), .i_midi_data (line1), .i_msg_ready (msg_ready),
    .o_msg_valid (valid1), .o_msg_data (data1), .o_msg_len (len1),
    .o_busy_reading (busy1), .o_framing_err (ferr1), .o_overflow (ovf1)
  );

  midi_rx_parser #(
    .CLKS_PER_BIT (CPB), .SYNC_STAGES (2), .FIFO_DEPTH (DEPTH), .CHANNEL_MASK (16'h0001)
  ) dut_mask (
    .i_clock (clk), .i_clr (rst_n), .i_midi_data (line2), .i_msg_ready (ready2),
    .o_msg_valid (valid2), .o_msg_data (data2), .o_msg_len (len2),
    .o_busy_reading (busy2), .o_framing_err (ferr2), .o_overflow (ovf2)
  );

  int errors = 0;
  int checks = 0;

  // ------------------------------------------------------------- model state
  logic [25:0] expq [$];      // {len, status, d1, d2} in arrival order
  logic        exp_ovf = 1'b0;
  logic [7:0]  m_status;
  bit          m_have;
  int          m_need;
  logic [7:0]  m_data [$];
  bit          m_sysex;

  task automatic model_reset();
    expq.delete();
    m_data.delete();
    exp_ovf  = 1'b0;
    m_have   = 0;
    m_sysex  = 0;
    m_status = 8'h00;
    m_need   = 0;
  endtask

  task automatic exp_push(input logic [1:0] len, input logic [23:0] d);
    if (expq.size() >= DEPTH && !msg_ready) exp_ovf = 1'b1;
    else expq.push_back({len, d});
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b >= 8'hF8) begin
      exp_push(2'd1, {b, 16'h0000});
    end else if (b >= 8'h80) begin
      m_sysex = 0;
      m_have  = 0;
      m_data.delete();
      if (b < 8'hF0) begin
        m_have   = 1;
        m_status = b;
        m_need   = (b[7:4] == 4'hC || b[7:4] == 4'hD) ? 1 : 2;
      end else begin
        case (b)
          8'hF0: m_sysex = 1;
          8'hF1, 8'hF3: begin m_have = 1; m_status = b; m_need = 1; end
          8'hF2: begin m_have = 1; m_status = b; m_need = 2; end
          8'hF6: exp_push(2'd1, {b, 16'h0000});
          default: ;
        endcase
      end
    end else if (!m_sysex && m_have) begin
      m_data.push_back(b);
      if (m_data.size() == m_need) begin
        if (m_status >= 8'hF0 || MASK1[m_status[3:0]])
          exp_push(2'(m_need + 1), {m_status, m_data[0], (m_need == 2) ? m_data[1] : 8'h00});
        m_data.delete();
        if (m_status >= 8'hF0) m_have = 0;
      end
    end
  endtask

  task automatic model_ferr();
    m_have  = 0;
    m_sysex = 0;
    m_data.delete();
  endtask

  // --------------------------------------------------------- compare process
  logic [23:0] last_data = '0;
  logic [1:0]  last_len  = '0;
  bit          hold_prev = 0;
  logic [25:0] hold_val;
  int          ferr_cnt = 0;
  int          d2_cnt = 0;
  logic [23:0] d2_last = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_prev) begin
        checks++;
        if ({len1, data1} !== hold_val) begin
          errors++;
          $display("FAIL hold_stable: got %h expected %h", {len1, data1}, hold_val);
        end
      end
      if (valid1 && msg_ready) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_msg: got len=%0d data=%h expected none", len1, data1);
        end else begin
          logic [25:0] e;
          e = expq.pop_front();
          if ({len1, data1} !== e) begin
            errors++;
            $display("FAIL msg: got len=%0d data=%h expected len=%0d data=%h",
                     len1, data1, e[25:24], e[23:0]);
          end
        end
        last_data = data1;
        last_len  = len1;
      end
      hold_prev = valid1 && !msg_ready;
      hold_val  = {len1, data1};
      if (ferr1) ferr_cnt++;
      if (valid2 && ready2) begin
        d2_cnt++;
        d2_last = data2;
      end
    end else begin
      hold_prev = 0;
    end
  end

  // ----------------------------------------------------------------- helpers
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_line(input bit which2, input logic v);
    if (which2) line2 = v;
    else line1 = v;
  endtask

  // 8N1 frame, then one idle bit time. The model sees the byte at the start
  // of the stop bit, before the receiver samples it.
  task automatic send(input logic [7:0] b, input bit stop_ok, input bit which2);
    set_line(which2, 1'b0);
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      set_line(which2, b[i]);
      tick(CPB);
    end
    if (!which2) begin
      if (stop_ok) model_byte(b);
      else model_ferr();
    end
    set_line(which2, stop_ok);
    tick(CPB);
    set_line(which2, 1'b1);
    tick(CPB);
  endtask

  task automatic check_drained(input string name);
    tick(20);
    chk(name, expq.size(), 0);
  endtask

  // ------------------------------------------------------------------- test
  initial begin
    int f0;
    model_reset();
    tick(3);
    chk("reset_valid", valid1, 0);
    chk("reset_data", data1, 0);
    chk("reset_busy", busy1, 0);
    chk("reset_ovf", ovf1, 0);
    rst_n = 1'b1;
    tick(10);

    // Single note-on
    send(8'h90, 1, 0); send(8'h3C, 1, 0);
    chk("busy_between_frames", busy1, 0);
    send(8'h64, 1, 0);
    check_drained("t1_drained");
    chk("t1_literal_data", last_data, 24'h903C64);
    chk("t1_literal_len", last_len, 3);

    // Running status
    send(8'h90, 1, 0); send(8'h3C, 1, 0); send(8'h64, 1, 0);
    send(8'h3C, 1, 0); send(8'h00, 1, 0);
    check_drained("t2_drained");
    chk("t2_literal_data", last_data, 24'h903C00);

    // Real-time interleave, then SysEx skip and program change
    send(8'h90, 1, 0); send(8'h3C, 1, 0); send(8'hF8, 1, 0); send(8'h64, 1, 0);
    check_drained("t3_drained");
    foreach (m_data[i]) ;
    send(8'hF0, 1, 0); send(8'h01, 1, 0); send(8'h02, 1, 0); send(8'hF7, 1, 0);
    send(8'hC5, 1, 0); send(8'h07, 1, 0);
    check_drained("t3b_drained");
    chk("t3b_literal_data", last_data, 24'hC50700);
    chk("t3b_literal_len", last_len, 2);

    // Framing error mid-message, then an orphan data byte
    f0 = ferr_cnt;
    send(8'h90, 1, 0); send(8'h3C, 0, 0); send(8'h64, 1, 0);
    check_drained("t4_drained");
    chk("t4_ferr_pulses", ferr_cnt - f0, 1);
    chk("t4_last_unchanged", last_data, 24'hC50700);

    // Short low glitch on an idle line
    f0 = ferr_cnt;
    line1 = 1'b0; tick(4); line1 = 1'b1;
    tick(3 * CPB);
    chk("t5_glitch_ferr", ferr_cnt - f0, 0);
    chk("t5_glitch_busy", busy1, 0);
    check_drained("t5_drained");

    // Channel filter on the second instance (only channel 0 passes)
    send(8'h91, 1, 1); send(8'h3C, 1, 1); send(8'h64, 1, 1);
    tick(20);
    chk("t6_masked_none", d2_cnt, 0);
    send(8'h90, 1, 1); send(8'h3C, 1, 1); send(8'h64, 1, 1);
    tick(20);
    chk("t6_ch0_count", d2_cnt, 1);
    chk("t6_ch0_data", d2_last, 24'h903C64);

    // Overflow: five note-ons with the consumer stalled
    msg_ready = 1'b0;
    send(8'h90, 1, 0); send(8'h3C, 1, 0); send(8'h64, 1, 0);
    send(8'h3D, 1, 0); send(8'h64, 1, 0);
    send(8'h3E, 1, 0); send(8'h64, 1, 0);
    send(8'h3F, 1, 0); send(8'h64, 1, 0);
    send(8'h40, 1, 0); send(8'h64, 1, 0);
    tick(10);
    chk("t7_model_held", expq.size(), 4);
    chk("t7_overflow", ovf1, 1);
    chk("t7_model_ovf", exp_ovf, 1);
    chk("t7_valid_held", valid1, 1);
    chk("t7_head_data", data1, 24'h903C64);
    msg_ready = 1'b1;
    check_drained("t7_drained");
    chk("t7_last_drained", last_data, 24'h903F64);
    chk("t7_valid_empty", valid1, 0);

    // Reset in the middle of a frame
    line1 = 1'b0;
    tick(3 * CPB);
    rst_n = 1'b0;
    tick(3);
    chk("t8_rst_ovf", ovf1, 0);
    chk("t8_rst_valid", valid1, 0);
    chk("t8_rst_busy", busy1, 0);
    line1 = 1'b1;
    tick(3);
    model_reset();
    rst_n = 1'b1;
    tick(20);
    send(8'h90, 1, 0); send(8'h3C, 1, 0); send(8'h64, 1, 0);
    check_drained("t8_drained");
    chk("t8_literal_data", last_data, 24'h903C64);
    chk("t8_ovf_clear", ovf1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
